unified_mem_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory between instruction fetch (IF) and
//  the MEM-stage load/store port (DM) through per-port req/ready handshakes. Replaces the

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_lat_counter.sv | 27 ++
 rtl/unified_mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory arbiter: FSM states, grant
// encoding and the fixed func3 used for instruction fetches.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_DM = 1'b1
    } grant_t;

    // Fetches are always full-word reads.
    localparam logic [2:0] IF_FUNC3 = 3'b010;

endpackage

// File: rtl/arb_lat_counter.sv
// Load/enable up-counter with a terminal-count flag, used to time how long
// the arbiter holds an access on the memory.
module arb_lat_counter #(
    parameter int WIDTH    = 1,
    parameter int TC_VALUE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == WIDTH'(TC_VALUE));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single unified memory between instruction fetch and the
// MEM-stage data port; DM has priority with a bounded streak so IF cannot starve.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 32,
    parameter int MEM_LATENCY   = 1,
    parameter int MAX_DM_STREAK = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [2:0]        dm_func3,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int LAT_W    = $clog2(MEM_LATENCY + 1);
    localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);

    arb_state_t          state;
    arb_state_t          state_next;
    grant_t              txn_port;
    logic                txn_we;
    logic [ADDR_W-1:0]   txn_addr;
    logic [DATA_W-1:0]   txn_wdata;
    logic [2:0]          txn_func3;
    logic [DATA_W-1:0]   txn_rdata;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   dm_rdata_q;
    logic                flushed;
    logic [STREAK_W-1:0] dm_streak;
    logic [LAT_W-1:0]    lat_cnt;
    logic                lat_tc;
    logic                grant_valid;
    grant_t              grant_sel;
    logic                if_eligible;

    // A flush in IDLE withdraws the fetch before it can be granted.
    assign if_eligible = if_req && !if_flush;

    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = GRANT_DM;
        if (dm_req && if_eligible) begin
            grant_valid = 1'b1;
            grant_sel   = (dm_streak == STREAK_W'(MAX_DM_STREAK)) ? GRANT_IF : GRANT_DM;
        end else if (dm_req) begin
            grant_valid = 1'b1;
            grant_sel   = GRANT_DM;
        end else if (if_eligible) begin
            grant_valid = 1'b1;
            grant_sel   = GRANT_IF;
        end
    end

    arb_lat_counter #(
        .WIDTH    (LAT_W),
        .TC_VALUE (MEM_LATENCY - 1)
    ) u_lat_counter (
        .clock  (clock),
        .reset  (reset),
        .load   (state != ISSUE),
        .enable ((state == ISSUE) && !lat_tc),
        .count  (lat_cnt),
        .tc     (lat_tc)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_func3  = '0;
        if_ready   = 1'b0;
        dm_ready   = 1'b0;
        if_rdata   = if_rdata_q;
        dm_rdata   = dm_rdata_q;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = txn_we;
                mem_addr  = txn_addr;
                mem_wdata = txn_wdata;
                mem_func3 = txn_func3;
                if (lat_tc) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                if (txn_port == GRANT_IF) begin
                    // A flush seen at any point of the fetch hides its result.
                    if (!flushed && !if_flush) begin
                        if_ready = 1'b1;
                        if_rdata = txn_rdata;
                    end
                end else begin
                    dm_ready = 1'b1;
                    if (!txn_we) begin
                        dm_rdata = txn_rdata;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            txn_port   <= GRANT_IF;
            txn_we     <= 1'b0;
            txn_addr   <= '0;
            txn_wdata  <= '0;
            txn_func3  <= '0;
            txn_rdata  <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            flushed    <= 1'b0;
        end else begin
            if (state == IDLE && grant_valid) begin
                txn_port <= grant_sel;
                if (grant_sel == GRANT_DM) begin
                    txn_we    <= dm_we;
                    txn_addr  <= dm_addr;
                    txn_wdata <= dm_wdata;
                    txn_func3 <= dm_func3;
                end else begin
                    txn_we    <= 1'b0;
                    txn_addr  <= if_addr;
                    txn_wdata <= '0;
                    txn_func3 <= IF_FUNC3;
                end
            end
            if (state == ISSUE && lat_tc) begin
                txn_rdata <= mem_rdata;
            end
            if (if_ready) begin
                if_rdata_q <= txn_rdata;
            end
            if (dm_ready && !txn_we) begin
                dm_rdata_q <= txn_rdata;
            end
            if (state == IDLE) begin
                flushed <= 1'b0;
            end else if (txn_port == GRANT_IF && if_flush) begin
                flushed <= 1'b1;
            end
        end
    end

    // The streak only grows while IF is actually waiting behind DM.
    always_ff @(posedge clock) begin
        if (!reset) begin
            dm_streak <= '0;
        end else if (state == IDLE) begin
            if (grant_valid && grant_sel == GRANT_IF) begin
                dm_streak <= '0;
            end else if (!if_req) begin
                dm_streak <= '0;
            end else if (grant_valid && dm_streak != STREAK_W'(MAX_DM_STREAK)) begin
                dm_streak <= dm_streak + STREAK_W'(1);
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench: a MEM_LATENCY=1 arbiter for the main scenarios
// and a MEM_LATENCY=4 arbiter for mid-access reset and long-latency timing.
module tb_unified_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        reset4;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_flush;
    logic        dm_req;
    logic        dm_we;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_func3;
    logic [31:0] mem_rdata;

    logic        if_ready,  dm_ready,  mem_en,  mem_we,  busy;
    logic [31:0] if_rdata,  dm_rdata,  mem_wdata;
    logic [7:0]  mem_addr;
    logic [2:0]  mem_func3;

    logic        if_ready4, dm_ready4, mem_en4, mem_we4, busy4;
    logic [31:0] if_rdata4, dm_rdata4, mem_wdata4;
    logic [7:0]  mem_addr4;
    logic [2:0]  mem_func34;

    int num_compared   = 0;
    int num_mismatched = 0;

    unified_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LATENCY(1), .MAX_DM_STREAK(3)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_func3(dm_func3), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_func3(mem_func3), .mem_rdata(mem_rdata), .busy(busy)
    );

    unified_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LATENCY(4), .MAX_DM_STREAK(3)) dut4 (
        .clock(clock), .reset(reset4),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready4), .if_rdata(if_rdata4),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_func3(dm_func3), .dm_ready(dm_ready4), .dm_rdata(dm_rdata4),
        .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .mem_func3(mem_func34), .mem_rdata(mem_rdata), .busy(busy4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_compared++;
        assert (observed === expected) else begin
            num_mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b0; reset4 = 1'b0;
        if_req = 1'b1; if_addr = 8'h04; if_flush = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h10; dm_wdata = '0; dm_func3 = 3'b010;
        mem_rdata = 32'hFFFF_FFFF;

        // Reset held with both requests active.
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("rst_busy",     32'(busy),     32'd0);
            checkOutput("rst_mem_en",   32'(mem_en),   32'd0);
            checkOutput("rst_if_ready", 32'(if_ready), 32'd0);
            checkOutput("rst_dm_ready", 32'(dm_ready), 32'd0);
            checkOutput("rst_if_rdata", if_rdata,      32'd0);
            checkOutput("rst_dm_rdata", dm_rdata,      32'd0);
            checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        end
        reset = 1'b1; if_req = 1'b0; dm_req = 1'b0;
        applyStimulus();
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Single fetch: accepted now, mem_en only next cycle, ready the one after.
        if_req = 1'b1; if_addr = 8'h04;
        checkOutput("if_acc_mem_en", 32'(mem_en), 32'd0);
        applyStimulus();
        checkOutput("if_iss_mem_en",  32'(mem_en),    32'd1);
        checkOutput("if_iss_addr",    32'(mem_addr),  32'h04);
        checkOutput("if_iss_func3",   32'(mem_func3), 32'd2);
        checkOutput("if_iss_we",      32'(mem_we),    32'd0);
        checkOutput("if_iss_ready",   32'(if_ready),  32'd0);
        mem_rdata = 32'h0050_0093;
        applyStimulus();
        checkOutput("if_done_ready",  32'(if_ready),  32'd1);
        checkOutput("if_done_rdata",  if_rdata,       32'h0050_0093);
        checkOutput("if_done_mem_en", 32'(mem_en),    32'd0);
        if_req = 1'b0;
        applyStimulus();
        checkOutput("if_after_ready", 32'(if_ready),  32'd0);
        checkOutput("if_after_rdata", if_rdata,       32'h0050_0093);
        checkOutput("if_after_busy",  32'(busy),      32'd0);

        // Load, so that a following store can be seen not to disturb dm_rdata.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h30; dm_func3 = 3'b100;
        applyStimulus();
        checkOutput("ld_iss_addr",  32'(mem_addr),  32'h30);
        checkOutput("ld_iss_func3", 32'(mem_func3), 32'd4);
        checkOutput("ld_iss_we",    32'(mem_we),    32'd0);
        mem_rdata = 32'hCAFE_F00D;
        applyStimulus();
        checkOutput("ld_done_ready", 32'(dm_ready), 32'd1);
        checkOutput("ld_done_rdata", dm_rdata,      32'hCAFE_F00D);
        checkOutput("ld_done_ifrdy", 32'(if_ready), 32'd0);
        dm_req = 1'b0;
        applyStimulus();
        checkOutput("ld_after_ready", 32'(dm_ready), 32'd0);

        // Store.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h10; dm_wdata = 32'hDEAD_BEEF; dm_func3 = 3'b010;
        applyStimulus();
        checkOutput("st_iss_we",    32'(mem_we),    32'd1);
        checkOutput("st_iss_en",    32'(mem_en),    32'd1);
        checkOutput("st_iss_addr",  32'(mem_addr),  32'h10);
        checkOutput("st_iss_wdata", mem_wdata,      32'hDEAD_BEEF);
        checkOutput("st_iss_func3", 32'(mem_func3), 32'd2);
        mem_rdata = 32'h1234_5678;
        applyStimulus();
        checkOutput("st_done_ready", 32'(dm_ready), 32'd1);
        checkOutput("st_done_rdata", dm_rdata,      32'hCAFE_F00D);
        checkOutput("st_done_we",    32'(mem_we),   32'd0);
        dm_req = 1'b0; dm_we = 1'b0;
        applyStimulus();

        // Contention: both held -> DM,DM,DM,IF,DM.
        if_req = 1'b1; if_addr = 8'h04; dm_req = 1'b1; dm_addr = 8'h10;
        mem_rdata = 32'h1111_0000;
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            applyStimulus();
            checkOutput($sformatf("cont%0d_dm_ready", k), 32'(dm_ready), (k == 3) ? 32'd0 : 32'd1);
            checkOutput($sformatf("cont%0d_if_ready", k), 32'(if_ready), (k == 3) ? 32'd1 : 32'd0);
            if (k == 4) begin
                if_req = 1'b0; dm_req = 1'b0;
            end
            applyStimulus();
        end
        checkOutput("cont_if_rdata", if_rdata, 32'h1111_0000);

        // Flush during an IF access hides its result.
        if_req = 1'b1; if_addr = 8'h40;
        applyStimulus();
        checkOutput("fl_iss_addr", 32'(mem_addr), 32'h40);
        if_flush = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        applyStimulus();
        if_flush = 1'b0; if_addr = 8'h20;
        checkOutput("fl_done_ready", 32'(if_ready), 32'd0);
        checkOutput("fl_done_rdata", if_rdata,      32'h1111_0000);
        applyStimulus();
        checkOutput("fl_idle_busy",  32'(busy),     32'd0);
        applyStimulus();
        checkOutput("fl2_iss_addr",  32'(mem_addr), 32'h20);
        mem_rdata = 32'h00A0_0113;
        applyStimulus();
        checkOutput("fl2_done_ready", 32'(if_ready), 32'd1);
        checkOutput("fl2_done_rdata", if_rdata,      32'h00A0_0113);
        if_req = 1'b0;
        applyStimulus();

        // Flush in IDLE suppresses the fetch grant.
        if_req = 1'b1; if_flush = 1'b1;
        applyStimulus();
        checkOutput("fl_idle_nogrant", 32'(busy), 32'd0);
        if_req = 1'b0; if_flush = 1'b0;
        applyStimulus();

        // MEM_LATENCY=4: reset arriving at lat_cnt==2 aborts the access.
        reset4 = 1'b1;
        applyStimulus();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h10; if_req = 1'b1; if_addr = 8'h04;
        mem_rdata = 32'h5555_AAAA;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("l4_lat_cnt",   32'(dut4.lat_cnt),   32'd2);
        checkOutput("l4_streak",    32'(dut4.dm_streak), 32'd1);
        checkOutput("l4_mem_en",    32'(mem_en4),        32'd1);
        reset4 = 1'b0;
        applyStimulus();
        checkOutput("l4_rst_busy",   32'(busy4),          32'd0);
        checkOutput("l4_rst_mem_en", 32'(mem_en4),        32'd0);
        checkOutput("l4_rst_ready",  32'(dm_ready4),      32'd0);
        checkOutput("l4_rst_streak", 32'(dut4.dm_streak), 32'd0);
        reset4 = 1'b1; dm_req = 1'b0; if_req = 1'b0;
        applyStimulus();
        checkOutput("l4_post_ready", 32'(dm_ready4), 32'd0);
        checkOutput("l4_post_rdata", dm_rdata4,      32'd0);

        // MEM_LATENCY=4 full load: mem_en for four cycles, ready on the fifth.
        dm_req = 1'b1; dm_addr = 8'h44;
        mem_rdata = 32'h0BAD_C0DE;
        for (int c = 0; c < 4; c++) begin
            applyStimulus();
            checkOutput($sformatf("l4_iss%0d_en", c),    32'(mem_en4),   32'd1);
            checkOutput($sformatf("l4_iss%0d_ready", c), 32'(dm_ready4), 32'd0);
        end
        applyStimulus();
        checkOutput("l4_done_ready", 32'(dm_ready4), 32'd1);
        checkOutput("l4_done_rdata", dm_rdata4,      32'h0BAD_C0DE);
        dm_req = 1'b0;
        applyStimulus();
        checkOutput("l4_idle_busy", 32'(busy4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
